instruction_fetch_pipe: RTL and testbench
=========================================

Name: instruction_fetch_pipe

Overview:
Parametrised instruction-fetch stage: PC register, next-PC selection, a synchronous instruction-memory interface with 1-cycle read latency, and an IF/ID-facing output with valid, stall and flush semantics.
- Adds stall with instruction hold, redirect-with-flush (absolute or PC-relative) and a reset PC.
- Sits between the instruction memory and the decode stage.
- Redirect and stall requests come from later pipeline stages (branch/jump resolution, hazard unit).

Parameters:
ADDR_W, 10, PC / instruction-memory word-address width
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold the fetch stage (PC, outputs) this cycle
redirect_en  in  1  load a new PC and flush the in-flight fetch
redirect_rel  in  1  0: redirect_target is an absolute address; 1: signed offset added to pc_plus_1
redirect_target  in  ADDR_W  absolute address or two's-complement offset
imem_addr  out  ADDR_W  address to synchronous instruction memory (= pc_q)
imem_data  in  DATA_W  memory read data, valid one cycle after imem_addr
instr  out  DATA_W  fetched instruction to decode
pc_out  out  ADDR_W  address of instr
pc_plus_1  out  ADDR_W  pc_out + 1, modulo 2^ADDR_W
valid  out  1  instr/pc_out are a real instruction (0 = bubble)

Behaviour:
State: pc_q (next address to fetch), req_pc_q (address whose data is on imem_data), req_v_q, hold_q (DATA_W), hold_v.

Combinational outputs:
- imem_addr = pc_q
- pc_out = req_pc_q
- pc_plus_1 = req_pc_q + 1, wrapping at 2^ADDR_W
- valid = req_v_q
- instr = hold_v ? hold_q : imem_data

Reset (highest priority, synchronous):
- pc_q = RESET_PC, req_pc_q = RESET_PC, req_v_q = 0, hold_v = 0, hold_q = 0.
- Outputs therefore read valid = 0, pc_out = RESET_PC, pc_plus_1 = RESET_PC + 1.
- Reset asserted mid-operation discards everything in flight, and valid is 0 on the following cycle.

Redirect (priority over stall):
- Target = redirect_rel ? (pc_plus_1 + redirect_target) : redirect_target.
- The add is ADDR_W-bit, signed offset, wraps modulo 2^ADDR_W.
- On the edge: pc_q = target, req_v_q = 0, hold_v = 0; req_pc_q is unchanged (don't-care).
- Next cycle valid = 0.
- The cycle after that: valid = 1, pc_out = target, instr = mem[target], provided there is no stall.
- Redirect while stalled is accepted immediately and cancels the stall for that edge.

Stall (no redirect, no reset):
- pc_q, req_pc_q and req_v_q hold.
- If hold_v = 0, capture hold_q = imem_data and set hold_v = 1, so instr stays stable although memory keeps reading pc_q.
- While hold_v = 1, hold_q holds.

Advance (no stall, no redirect, no reset):
- req_pc_q = pc_q, req_v_q = 1, pc_q = pc_q + 1 (wraps from 2^ADDR_W-1 to 0), hold_v = 0.

Latency and throughput:
- Latency is 1 cycle from address to instruction.
- Throughput is 1 instruction per cycle when not stalled.
- After reset release, the first valid instruction (mem[RESET_PC]) appears the cycle after the first non-reset edge.
- When stall is held for N cycles the outputs are frozen for those N cycles. After release, the next instruction is mem[pc_q] with no loss or duplication.

Test Plan:
- Sequential fetch: reset, then 6 free cycles with mem[i] = 0x1000+i → valid = 0 for 1 cycle, then pc_out 0,1,2,3,4 with instr 0x1000..0x1004; pc_plus_1 = pc_out + 1.
- Stall hold: stall for 3 cycles while pc_out = 2 → instr = 0x1002, pc_out = 2 and valid = 1 stable for all 3 cycles; after release the next outputs are pc 3, then pc 4 (no skip or repeat).
- Absolute redirect: redirect_en = 1, redirect_target = 0x200 while pc_out = 4 → next cycle valid = 0; following cycle pc_out = 0x200, instr = mem[0x200].
- Relative redirect with wrap, ADDR_W = 10:
  - pc_out = 0x3FE (pc_plus_1 = 0x3FF), offset 0x002 → target 0x001.
  - offset 0x3FC (-4) from pc_out = 0x010 → target 0x00D.
- Redirect during stall: stall = 1 and redirect_en = 1 with target 0x050 on the same edge → redirect wins; bubble, then pc_out = 0x050; hold_v cleared (instr tracks memory).
- Reset mid-stream and PC wrap:
  - reset asserted with stall = 1 and pc_out = 7 → next cycle valid = 0, imem_addr = RESET_PC.
  - Run through address 0x3FF → next pc_out = 0x000.

Source files
------------

// File: rtl/instruction_fetch_pipe.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pipe
//
// Instruction-fetch stage between a synchronous instruction memory (1-cycle
// read latency) and the decode stage. Holds the PC, selects the next PC
// (sequential, absolute redirect or PC-relative redirect), and presents the
// fetched instruction with valid / stall / flush semantics.
//
// Ports:
//   clock            in   system clock, rising-edge state updates
//   reset            in   synchronous active-high reset
//   stall            in   freeze PC and outputs this cycle
//   redirect_en      in   load new PC, flush in-flight fetch (beats stall)
//   redirect_rel     in   0: absolute target, 1: signed offset from pc_plus_1
//   redirect_target  in   absolute address or two's-complement offset
//   imem_addr        out  address to instruction memory (= pc_q)
//   imem_data        in   memory read data for the previous imem_addr
//   instr            out  fetched instruction
//   pc_out           out  address of instr
//   pc_plus_1        out  pc_out + 1, modulo 2^ADDR_W
//   valid            out  instr/pc_out hold a real instruction
// ---------------------------------------------------------------------------
module instruction_fetch_pipe #(
    parameter int unsigned            ADDR_W   = 10,
    parameter int unsigned            DATA_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic              redirect_rel,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus_1,
    output logic              valid
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_v_q,  req_v_d;
    logic [DATA_W-1:0] hold_q,   hold_d;
    logic              hold_v_q, hold_v_d;
    logic [ADDR_W-1:0] target;

    assign imem_addr = pc_q;
    assign pc_out    = req_pc_q;
    assign pc_plus_1 = req_pc_q + ONE;
    assign valid     = req_v_q;
    // Once stalled, memory keeps reading pc_q, so the captured word is shown
    // instead of the live read data.
    assign instr     = hold_v_q ? hold_q : imem_data;

    // Relative offset is two's complement; ADDR_W-bit add wraps naturally.
    assign target = redirect_rel ? (pc_plus_1 + redirect_target) : redirect_target;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        req_v_d  = req_v_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (redirect_en) begin
            // Flush: the word arriving next cycle belongs to the old path.
            pc_d     = target;
            req_v_d  = 1'b0;
            hold_v_d = 1'b0;
        end else if (stall) begin
            if (!hold_v_q) begin
                hold_d   = imem_data;
                hold_v_d = 1'b1;
            end
        end else begin
            req_pc_d = pc_q;
            req_v_d  = 1'b1;
            pc_d     = pc_q + ONE;
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            req_v_q  <= 1'b0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_v_q  <= req_v_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_pipe.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_pipe
//
// Directed bench for instruction_fetch_pipe. The instruction memory model
// returns 0x1000 + address one cycle after the address is presented.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_pipe;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic              redirect_en = 1'b0;
    logic              redirect_rel = 1'b0;
    logic [ADDR_W-1:0] redirect_target = '0;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data = '0;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus_1;
    logic              valid;

    int errors = 0;
    int checks = 0;

    instruction_fetch_pipe #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC ('0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_rel    (redirect_rel),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .instr           (instr),
        .pc_out          (pc_out),
        .pc_plus_1       (pc_plus_1),
        .valid           (valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_data <= 32'h1000 + 32'(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".pc_out"}, 32'(pc_out), pc);
        check({tag, ".pc_plus_1"}, 32'(pc_plus_1), (pc + 32'd1) & 32'h3FF);
        if (v) check({tag, ".instr"}, instr, ins);
    endtask

    task automatic redirect_abs(input logic [ADDR_W-1:0] t);
        redirect_en = 1'b1; redirect_rel = 1'b0; redirect_target = t;
        tick();
        redirect_en = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.pc_out", 32'(pc_out), 32'h000);
        check("rst.pc_plus_1", 32'(pc_plus_1), 32'h001);
        check("rst.imem_addr", 32'(imem_addr), 32'h000);

        // Sequential fetch: first valid instruction after the first free edge
        reset = 1'b0;
        tick();
        expect_out("seq0", 1'b1, 32'h000, 32'h1000);
        for (int i = 1; i <= 2; i++) begin
            tick();
            expect_out("seq", 1'b1, 32'(i), 32'h1000 + 32'(i));
        end

        // Stall for 3 cycles with pc_out = 2
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall", 1'b1, 32'h002, 32'h1002);
            check("stall.imem_addr", 32'(imem_addr), 32'h003);
        end
        stall = 1'b0;
        tick();
        expect_out("post_stall3", 1'b1, 32'h003, 32'h1003);
        tick();
        expect_out("post_stall4", 1'b1, 32'h004, 32'h1004);

        // Absolute redirect to 0x200
        redirect_en = 1'b1; redirect_rel = 1'b0; redirect_target = 10'h200;
        tick();
        check("abs.bubble", 32'(valid), 32'd0);
        check("abs.imem_addr", 32'(imem_addr), 32'h200);
        redirect_en = 1'b0;
        tick();
        expect_out("abs", 1'b1, 32'h200, 32'h1200);

        // Relative redirect wrapping past the top: 0x3FF + 2 -> 0x001
        redirect_abs(10'h3FE);
        expect_out("at3fe", 1'b1, 32'h3FE, 32'h13FE);
        redirect_en = 1'b1; redirect_rel = 1'b1; redirect_target = 10'h002;
        tick();
        check("rel1.bubble", 32'(valid), 32'd0);
        check("rel1.imem_addr", 32'(imem_addr), 32'h001);
        redirect_en = 1'b0; redirect_rel = 1'b0;
        tick();
        expect_out("rel1", 1'b1, 32'h001, 32'h1001);

        // Negative offset: 0x011 + (-4) -> 0x00D
        redirect_abs(10'h010);
        expect_out("at010", 1'b1, 32'h010, 32'h1010);
        redirect_en = 1'b1; redirect_rel = 1'b1; redirect_target = 10'h3FC;
        tick();
        check("rel2.imem_addr", 32'(imem_addr), 32'h00D);
        redirect_en = 1'b0; redirect_rel = 1'b0;
        tick();
        expect_out("rel2", 1'b1, 32'h00D, 32'h100D);

        // Redirect while stalled: redirect wins, hold cleared
        stall = 1'b1;
        tick();
        expect_out("pre_rds", 1'b1, 32'h00D, 32'h100D);
        redirect_en = 1'b1; redirect_target = 10'h050;
        tick();
        check("rds.bubble", 32'(valid), 32'd0);
        check("rds.imem_addr", 32'(imem_addr), 32'h050);
        redirect_en = 1'b0; stall = 1'b0;
        tick();
        expect_out("rds", 1'b1, 32'h050, 32'h1050);
        tick();
        expect_out("rds_next", 1'b1, 32'h051, 32'h1051);

        // Reset mid-stream while stalled at pc_out = 7
        redirect_abs(10'h007);
        expect_out("at007", 1'b1, 32'h007, 32'h1007);
        stall = 1'b1; reset = 1'b1;
        tick();
        check("mrst.valid", 32'(valid), 32'd0);
        check("mrst.imem_addr", 32'(imem_addr), 32'h000);
        check("mrst.pc_out", 32'(pc_out), 32'h000);
        stall = 1'b0; reset = 1'b0;
        tick();
        expect_out("mrst_first", 1'b1, 32'h000, 32'h1000);

        // PC wrap from 0x3FF to 0x000
        redirect_abs(10'h3FF);
        expect_out("at3ff", 1'b1, 32'h3FF, 32'h13FF);
        check("wrap.imem_addr", 32'(imem_addr), 32'h000);
        tick();
        expect_out("wrap", 1'b1, 32'h000, 32'h1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
